// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: FSM encodings,
// opcode constants and the default program-counter width.
package cpu_pkg;

  localparam int CPU_PC_W = 8;

  typedef logic [2:0] seq_state_t;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  // Opcode field is instr[7:3]; instr[2:0] selects the operand register.
  localparam logic [4:0] OP_LI     = 5'd1;
  localparam logic [4:0] OP_LD     = 5'd2;
  localparam logic [4:0] OP_ST     = 5'd3;
  localparam logic [4:0] OP_INC    = 5'd4;
  localparam logic [4:0] OP_GETACC = 5'd5;
  localparam logic [4:0] OP_SETACC = 5'd6;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Instruction- and data-memory bus between the sequencer (master) and the
// memories (slave).
//
// Handshake: a request (imem_req / dmem_req) is held high with its
// address / write-enable stable until the matching ack is seen high in the
// same cycle; the transfer completes on that cycle. An ack may coincide with
// the first request cycle (zero-wait). An ack with no request is ignored.
interface cpu_sequencer_if #(parameter int PC_W = 8);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [7:0]      imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );
endinterface

// File: rtl/seq_timeout_ctr.sv
// Wait-state counter for the sequencer's bus waits. Only instantiated when
// SEQ_TIMEOUT_EN is defined. expired is high on the TIMEOUT-th waiting cycle.
module seq_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT - 1));

  // Count waiting cycles; saturate once expired, restart on clear.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the 8-bit accumulator CPU:
// FETCH -> DECODE -> EXEC (one cycle) or MEM (req/ack) -> next FETCH.
// Optional bus-wait timeout with an absorbing FAULT state: define SEQ_TIMEOUT_EN.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W    = CPU_PC_W,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  cpu_sequencer_if.master        mem,
  output logic [7:0]             instr,
  input  logic                   is_mem_op,
  input  logic                   mem_rw,
  output logic                   reg_we,
  output logic [PC_W-1:0]        pc,
  output logic [2:0]             state_o,
  output logic                   fault
);

  seq_state_t state;
  seq_state_t state_nxt;
  logic [7:0] ir_q;
  logic       wait_expired;
  logic       imem_done;
  logic       dmem_done;

  // Acks only count in the state that issued the matching request.
  assign imem_done = (state == S_FETCH) && mem.imem_ack;
  assign dmem_done = (state == S_MEM) && mem.dmem_ack;

`ifdef SEQ_TIMEOUT_EN
  logic waiting;

  assign waiting = (state == S_FETCH) || (state == S_MEM);

  seq_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (!waiting || imem_done || dmem_done),
    .en      (waiting && !imem_done && !dmem_done),
    .expired (wait_expired)
  );

  assign fault = (state == S_FAULT);
`else
  assign wait_expired = 1'b0;
  assign fault        = 1'b0;
`endif

  // Next-state decode; run is only looked at between instructions.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (run) state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_done)         state_nxt = S_DECODE;
        else if (wait_expired) state_nxt = S_FAULT;
      end
      S_DECODE: state_nxt = is_mem_op ? S_MEM : S_EXEC;
      S_EXEC:   state_nxt = run ? S_FETCH : S_IDLE;
      S_MEM: begin
        if (dmem_done)         state_nxt = run ? S_FETCH : S_IDLE;
        else if (wait_expired) state_nxt = S_FAULT;
      end
      S_FAULT:  state_nxt = S_FAULT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State, program counter and instruction register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= '0;
      ir_q  <= '0;
    end else begin
      state <= state_nxt;
      if (imem_done) ir_q <= mem.imem_rdata;
      // pc wraps modulo 2^PC_W by construction.
      if ((state == S_EXEC) || dmem_done) pc <= pc + 1'b1;
    end
  end

  // Bus and strobe outputs decode directly from the current state.
  assign mem.imem_req  = (state == S_FETCH);
  assign mem.imem_addr = pc;
  assign mem.dmem_req  = (state == S_MEM);
  assign mem.dmem_we   = (state == S_MEM) && mem_rw;
  assign reg_we        = (state == S_EXEC) || (dmem_done && !mem_rw);
  assign instr         = ir_q;
  assign state_o       = state;

endmodule
